// File: rtl/uart_ctrl_unit.sv
// UART control unit: services send/read requests from the control register,
// drains the TX FIFO into the serializer and pops RX bytes. Optional TX watchdog: UART_TX_TIMEOUT_EN.
module uart_ctrl_unit #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_WIDTH   = 9,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_send_req,
  input  logic                 i_read_req,
  output logic                 o_scdc_clear_send,
  output logic                 o_scdc_clear_read,
  input  logic                 i_tx_fifo_empty,
  input  logic [DATA_W-1:0]    i_tx_fifo_data,
  output logic                 o_tx_fifo_pop,
  input  logic                 i_rx_fifo_empty,
  input  logic [DATA_W-1:0]    i_rx_fifo_data,
  output logic                 o_rx_fifo_pop,
  output logic                 o_uart_tx_start,
  output logic [DATA_W-1:0]    o_uart_tx_data,
  input  logic                 i_uart_tx_busy,
  output logic [DATA_W-1:0]    o_rx_data,
  output logic                 o_rx_data_valid,
  output logic [CNT_WIDTH-1:0] o_tx_sent_count,
  output logic                 o_busy,
  output logic                 o_tx_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_START,
    S_TX_ACK,
    S_TX_WAIT,
    S_TX_DONE,
    S_RX_POP,
    S_RX_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_hit_q, rx_hit_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 tx_start_q, tx_start_d;
  logic                 tx_pop_q, tx_pop_d;
  logic                 rx_pop_q, rx_pop_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 clr_send_q, clr_send_d;
  logic                 clr_read_q, clr_read_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_TIMEOUT_EN
  logic                 err_q, err_d;
`endif

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    rx_data_d = rx_data_q;
    rx_hit_d  = rx_hit_q;
    tmo_d     = tmo_q;
`ifdef UART_TX_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_read_req && !i_rx_fifo_empty) begin
          state_d  = S_RX_POP;
          rx_hit_d = 1'b1;
        end else if (i_read_req) begin
          state_d  = S_RX_DONE;
          rx_hit_d = 1'b0;
        end else if (i_send_req && i_tx_fifo_empty) begin
          state_d = S_TX_DONE;
          cnt_d   = '0;
        end else if (i_send_req && !i_uart_tx_busy) begin
          state_d = S_TX_START;
          cnt_d   = '0;
        end
      end
      S_TX_START: begin
        state_d   = S_TX_ACK;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        tx_data_d = i_tx_fifo_data;
        tmo_d     = '0;
      end
      // The watchdog counter only ends the wait when the timeout build is enabled.
      S_TX_ACK: begin
        if (i_uart_tx_busy) begin
          state_d = S_TX_WAIT;
`ifdef UART_TX_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_TX_DONE;
          err_d   = 1'b1;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_TX_WAIT: begin
        if (!i_uart_tx_busy) begin
          state_d = (i_send_req && !i_tx_fifo_empty) ? S_TX_START : S_TX_DONE;
        end
      end
      S_TX_DONE: state_d = S_IDLE;
      S_RX_POP: begin
        state_d   = S_RX_DONE;
        rx_data_d = i_rx_fifo_data;
      end
      S_RX_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
`ifdef UART_TX_TIMEOUT_EN
    if (state_d == S_TX_START) err_d = 1'b0;
`endif
    tx_start_d = (state_d == S_TX_START);
    tx_pop_d   = (state_d == S_TX_START);
    rx_pop_d   = (state_d == S_RX_POP);
    rx_valid_d = (state_d == S_RX_DONE) && rx_hit_d;
    clr_read_d = (state_d == S_RX_DONE);
    clr_send_d = (state_d == S_TX_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
      rx_hit_q   <= 1'b0;
      tmo_q      <= '0;
      tx_start_q <= 1'b0;
      tx_pop_q   <= 1'b0;
      rx_pop_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      clr_send_q <= 1'b0;
      clr_read_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      rx_data_q  <= rx_data_d;
      rx_hit_q   <= rx_hit_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_pop_q   <= tx_pop_d;
      rx_pop_q   <= rx_pop_d;
      rx_valid_q <= rx_valid_d;
      clr_send_q <= clr_send_d;
      clr_read_q <= clr_read_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign o_tx_err = err_q;
`else
  assign o_tx_err = 1'b0;
`endif

  assign o_scdc_clear_send = clr_send_q;
  assign o_scdc_clear_read = clr_read_q;
  assign o_tx_fifo_pop     = tx_pop_q;
  assign o_rx_fifo_pop     = rx_pop_q;
  assign o_uart_tx_start   = tx_start_q;
  assign o_uart_tx_data    = tx_data_q;
  assign o_rx_data         = rx_data_q;
  assign o_rx_data_valid   = rx_valid_q;
  assign o_tx_sent_count   = cnt_q;
  assign o_busy            = busy_q;

endmodule
